score_keeper: RTL
=================

Name: score_keeper

Overview:
- Match controller directly downstream of the ball stage.
- Watches the ball stage's leftScore/rightScore counters and runs the match state machine: idle, start countdown, play, serve pause, game over.
- Drives ballHold (ball update enable gate) and matchReset (pulse into the ball stage's Reset).
- Converts both scores to BCD for the score display stage.

Parameters:
- WinScore, 11, points needed to win a match (1..99)
- StartFrames, 120, frameTick count of the countdown before the first serve
- ServeFrames, 60, frameTick count of the pause after each point
- CntWidth, 8, width of the frame counter; must hold max(StartFrames, ServeFrames)

Ports:
- PixelClock  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  start button level, already debounced
- frameTick  input  1  one-cycle pulse per video frame
- leftScore  input  7  left player score from the ball stage
- rightScore  input  7  right player score from the ball stage
- ballHold  output  1  1 = ball frozen (ball stage must not advance)
- matchReset  output  1  one-cycle pulse; clears the ball stage's position and scores
- gameOver  output  1  high in OVER state
- winner  output  2  00 none, 01 left, 10 right
- leftTens, leftOnes  output  4 each  BCD of the left score
- rightTens, rightOnes  output  4 each  BCD of the right score

Behaviour:
Reset values:
- State IDLE; ballHold=1; matchReset=0; gameOver=0; winner=00; all BCD outputs 0.
- Frame counter 0; previous-score registers 0; Start edge register 0.

Start edge:
- startPulse = Start & ~StartQ, where StartQ is Start registered.
- Holding Start produces exactly one pulse.

States:
- IDLE: ballHold=1. On startPulse: assert matchReset for 1 cycle, clear counter, go to COUNT.
- COUNT: ballHold=1. Counter increments on frameTick. When the counter reaches StartFrames-1 and a frameTick arrives, go to PLAY. Duration is exactly StartFrames ticks.
- PLAY: ballHold=0.
  - Score event = input score > its previous-score register, compared every cycle; the previous register is then updated.
  - On a score event: if the win condition is met, go to OVER; else clear the counter and go to SERVE.
  - startPulse is ignored in PLAY.
- SERVE: ballHold=1. Same counting rule using ServeFrames, then go to PLAY.
- OVER: ballHold=1, gameOver=1, winner latched. On startPulse: matchReset pulse, winner cleared, gameOver cleared, go to COUNT.

Win condition:
- Side score >= WinScore.
- Both sides reaching it in the same cycle: higher score wins; a tie goes to left.

Score resync:
- An input score lower than its previous register (ball-stage reset) only reloads the register. No event.
- During the matchReset cycle, both previous registers load 0.

Scores while held:
- Score changes in IDLE, COUNT, SERVE or OVER update the previous registers but raise no event.

Reset priority:
- Reset mid-operation (any state, mid-conversion) returns everything to reset values the next cycle. It overrides startPulse and frameTick.

BCD conversion:
- Sequential double-dabble, both sides in parallel, 7 iterations (add 3 to any digit >= 5, then shift). A side is loaded when a conversion is idle and its snapshot differs from the last converted value.
- Latency from score change to BCD output: 8 cycles.
- All four digit outputs update together on the completion cycle.
- A score change arriving mid-conversion is captured at the next idle slot.
- Scores > 99: tens digit saturates at 9, ones digit 9.

Optional Feature:
- Macro: SCORE_WIN_BY_TWO_EN.
- Defined: win requires score >= WinScore AND lead >= 2 over the opponent (deuce play). Match continues past WinScore until the lead condition is met.
- Undefined: first to WinScore wins, regardless of margin.

Test Plan:
- Reset, then Start held 10 cycles, StartFrames=4 -> exactly one matchReset pulse; ballHold=1 for 4 frameTicks; PLAY with ballHold=0 on the cycle after the 4th tick.
- In PLAY, leftScore 0->1 -> SERVE, ballHold=1 for ServeFrames=3 ticks, then PLAY; leftTens=0, leftOnes=1 exactly 8 cycles after the change.
- WinScore=11, rightScore 10->11 -> OVER, gameOver=1, winner=10, ballHold=1; a further frameTick leaves state unchanged; startPulse -> matchReset pulse, winner=00, COUNT.
- leftScore drops 5->0 during PLAY without matchReset -> no SERVE entry, previous register=0; BCD outputs become 0/0 after 8 cycles.
- SCORE_WIN_BY_TWO_EN defined, scores 10-10, left reaches 11 -> SERVE (not OVER); left reaches 12 at 12-10 -> OVER, winner=01.
- Reset asserted mid-SERVE and mid-conversion -> next cycle: IDLE, ballHold=1, BCD outputs 0, no matchReset pulse.

Source files
------------

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Match controller downstream of the ball stage. Watches the
//                left/right score counters, runs the match state machine
//                (IDLE -> COUNT -> PLAY <-> SERVE -> OVER), gates the ball
//                stage through ballHold, pulses matchReset into the ball
//                stage, and converts both scores to BCD for the display.
//
//  Ports       : PixelClock             system clock
//                Reset                  synchronous active-high reset
//                Start                  debounced start button level
//                frameTick              one-cycle pulse per video frame
//                leftScore/rightScore   7-bit scores from the ball stage
//                ballHold               1 = ball stage frozen
//                matchReset             one-cycle clear pulse to ball stage
//                gameOver               high while in OVER
//                winner                 00 none, 01 left, 10 right
//                leftTens/leftOnes      BCD of left score (saturates at 99)
//                rightTens/rightOnes    BCD of right score (saturates at 99)
//
//  Options     : SCORE_WIN_BY_TWO_EN -- when defined, a win also needs a
//                lead of at least two points (deuce play).
//
//  Revision    : 1.0  initial release
// ============================================================================
module score_keeper #(
    parameter int WinScore    = 11,
    parameter int StartFrames = 120,
    parameter int ServeFrames = 60,
    parameter int CntWidth    = 8
) (
    input  logic       PixelClock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       frameTick,
    input  logic [6:0] leftScore,
    input  logic [6:0] rightScore,
    output logic       ballHold,
    output logic       matchReset,
    output logic       gameOver,
    output logic [1:0] winner,
    output logic [3:0] leftTens,
    output logic [3:0] leftOnes,
    output logic [3:0] rightTens,
    output logic [3:0] rightOnes
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_COUNT = 3'd1;
    localparam logic [2:0] c_ST_PLAY  = 3'd2;
    localparam logic [2:0] c_ST_SERVE = 3'd3;
    localparam logic [2:0] c_ST_OVER  = 3'd4;

    localparam logic [CntWidth-1:0] c_START_LAST = CntWidth'(StartFrames - 1);
    localparam logic [CntWidth-1:0] c_SERVE_LAST = CntWidth'(ServeFrames - 1);
    localparam logic [7:0]          c_WIN        = 8'(WinScore);
    localparam logic [2:0]          c_LAST_ITER  = 3'd6;

    // ------------------------------------------------------------------
    // Match control
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [CntWidth-1:0] r_cnt;
    logic                r_startQ;
    logic                r_matchReset;
    logic [1:0]          r_winner;
    logic [6:0]          r_prevLeft;
    logic [6:0]          r_prevRight;

    logic       w_startPulse;
    logic       w_leftEvent;
    logic       w_rightEvent;
    logic [7:0] w_left8;
    logic [7:0] w_right8;
    logic       w_leftWin;
    logic       w_rightWin;
    logic [1:0] w_winSel;

    assign w_startPulse = Start & ~r_startQ;
    assign w_leftEvent  = (leftScore  > r_prevLeft);
    assign w_rightEvent = (rightScore > r_prevRight);
    assign w_left8      = {1'b0, leftScore};
    assign w_right8     = {1'b0, rightScore};

`ifdef SCORE_WIN_BY_TWO_EN
    assign w_leftWin  = (w_left8  >= c_WIN) && (w_left8  >= (w_right8 + 8'd2));
    assign w_rightWin = (w_right8 >= c_WIN) && (w_right8 >= (w_left8  + 8'd2));
`else
    assign w_leftWin  = (w_left8  >= c_WIN);
    assign w_rightWin = (w_right8 >= c_WIN);
`endif

    // Simultaneous win: higher score takes it, a tie goes to the left.
    always_comb begin
        w_winSel = 2'b00;
        if (w_leftWin && w_rightWin) begin
            w_winSel = (w_left8 >= w_right8) ? 2'b01 : 2'b10;
        end else if (w_leftWin) begin
            w_winSel = 2'b01;
        end else if (w_rightWin) begin
            w_winSel = 2'b10;
        end
    end

    always_ff @(posedge PixelClock) begin
        if (Reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_startQ     <= 1'b0;
            r_matchReset <= 1'b0;
            r_winner     <= 2'b00;
            r_prevLeft   <= '0;
            r_prevRight  <= '0;
        end else begin
            r_startQ     <= Start;
            r_matchReset <= 1'b0;
            // Previous-score registers track the inputs every cycle, so a
            // drop (ball-stage reset) or a held-state change just resyncs.
            // The ball stage clears its scores in response to matchReset,
            // so the history is zeroed during that pulse.
            r_prevLeft   <= r_matchReset ? 7'd0 : leftScore;
            r_prevRight  <= r_matchReset ? 7'd0 : rightScore;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_startPulse) begin
                        r_matchReset <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= c_ST_COUNT;
                    end
                end
                c_ST_COUNT: begin
                    if (frameTick) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_START_LAST) begin
                            r_state <= c_ST_PLAY;
                        end
                    end
                end
                c_ST_PLAY: begin
                    if (w_leftEvent || w_rightEvent) begin
                        if (w_leftWin || w_rightWin) begin
                            r_winner <= w_winSel;
                            r_state  <= c_ST_OVER;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= c_ST_SERVE;
                        end
                    end
                end
                c_ST_SERVE: begin
                    if (frameTick) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_SERVE_LAST) begin
                            r_state <= c_ST_PLAY;
                        end
                    end
                end
                c_ST_OVER: begin
                    if (w_startPulse) begin
                        r_matchReset <= 1'b1;
                        r_winner     <= 2'b00;
                        r_cnt        <= '0;
                        r_state      <= c_ST_COUNT;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ballHold   = (r_state != c_ST_PLAY);
    assign gameOver   = (r_state == c_ST_OVER);
    assign matchReset = r_matchReset;
    assign winner     = r_winner;

    // ------------------------------------------------------------------
    // BCD conversion (double-dabble, both sides in lock-step)
    // Shift register layout: [16:15] hundreds, [14:11] tens, [10:7] ones,
    // [6:0] binary still to be shifted in.
    // ------------------------------------------------------------------
    function automatic logic [16:0] f_dabble(input logic [16:0] v);
        logic [16:0] t;
        t = v;
        if (t[10:7]  >= 4'd5) t[10:7]  = t[10:7]  + 4'd3;
        if (t[14:11] >= 4'd5) t[14:11] = t[14:11] + 4'd3;
        return {t[15:0], 1'b0};
    endfunction

    // Any non-zero hundreds digit pins the display at 99.
    function automatic logic [7:0] f_sat(input logic [16:0] v);
        return (v[16:15] != 2'b00) ? 8'h99 : v[14:7];
    endfunction

    logic        r_busy;
    logic [2:0]  r_iter;
    logic [16:0] r_convL;
    logic [16:0] r_convR;
    logic [6:0]  r_lastL;
    logic [6:0]  r_lastR;
    logic [7:0]  r_bcdL;
    logic [7:0]  r_bcdR;

    logic [16:0] w_nextL;
    logic [16:0] w_nextR;

    assign w_nextL = f_dabble(r_convL);
    assign w_nextR = f_dabble(r_convR);

    always_ff @(posedge PixelClock) begin
        if (Reset) begin
            r_busy  <= 1'b0;
            r_iter  <= '0;
            r_convL <= '0;
            r_convR <= '0;
            r_lastL <= '0;
            r_lastR <= '0;
            r_bcdL  <= '0;
            r_bcdR  <= '0;
        end else if (!r_busy) begin
            // Both sides reload together so the four digits always come
            // from one consistent snapshot and update on the same cycle.
            if ((leftScore != r_lastL) || (rightScore != r_lastR)) begin
                r_convL <= {10'd0, leftScore};
                r_convR <= {10'd0, rightScore};
                r_lastL <= leftScore;
                r_lastR <= rightScore;
                r_iter  <= '0;
                r_busy  <= 1'b1;
            end
        end else begin
            r_convL <= w_nextL;
            r_convR <= w_nextR;
            r_iter  <= r_iter + 1'b1;
            if (r_iter == c_LAST_ITER) begin
                r_busy <= 1'b0;
                r_bcdL <= f_sat(w_nextL);
                r_bcdR <= f_sat(w_nextR);
            end
        end
    end

    assign leftTens  = r_bcdL[7:4];
    assign leftOnes  = r_bcdL[3:0];
    assign rightTens = r_bcdR[7:4];
    assign rightOnes = r_bcdR[3:0];

endmodule
`default_nettype wire
